// File: rtl/br_pred_ctrl.sv
// Branch prediction controller: 2-bit saturating counter table with a shared write
// port (resolution updates vs. clear sweep), mispredict flush/redirect and statistics.
module br_pred_ctrl #(
   parameter int ENTRIES = 16,
   parameter int XLEN    = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr_req,
   output logic            busy,
   input  logic [XLEN-1:0] lk_pc,
   output logic            lk_pred,
   input  logic            upd_valid,
   output logic            upd_ready,
   input  logic [XLEN-1:0] upd_pc,
   input  logic            upd_taken,
   input  logic            upd_pred,
   input  logic [XLEN-1:0] upd_target,
   output logic            flush,
   output logic [XLEN-1:0] redirect_pc,
   output logic [31:0]     br_cnt,
   output logic [31:0]     mis_cnt
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

   // Handshake: an update is consumed on a rising edge where upd_valid && upd_ready.
   typedef enum logic {S_CLEAR, S_IDLE} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  sweep_q, sweep_d;
   logic              flush_q, flush_d;
   logic [XLEN-1:0]   redirect_q, redirect_d;
   logic [31:0]       br_cnt_q, br_cnt_d;
   logic [31:0]       mis_cnt_q, mis_cnt_d;
   logic [1:0]        table_q [ENTRIES];

   logic [IDX_W-1:0]  lk_idx, upd_idx;
   logic              upd_acc, mispredict;
   logic [1:0]        cnt_cur, cnt_new;
   logic              unused_pc_bits;

   assign lk_idx  = lk_pc[IDX_W+1:2];
   assign upd_idx = upd_pc[IDX_W+1:2];
   assign unused_pc_bits = ^{lk_pc[XLEN-1:IDX_W+2], lk_pc[1:0]};

   assign busy      = (state_q == S_CLEAR);
   assign upd_ready = (state_q == S_IDLE);
   assign lk_pred   = (state_q == S_IDLE) && table_q[lk_idx][1];

   assign flush       = flush_q;
   assign redirect_pc = redirect_q;
   assign br_cnt      = br_cnt_q;
   assign mis_cnt     = mis_cnt_q;

   always_comb begin
      state_d    = state_q;
      sweep_d    = sweep_q;
      flush_d    = 1'b0;
      redirect_d = redirect_q;
      br_cnt_d   = br_cnt_q;
      mis_cnt_d  = mis_cnt_q;
      upd_acc    = (state_q == S_IDLE) && upd_valid;
      mispredict = upd_acc && (upd_pred != upd_taken);
      cnt_cur    = table_q[upd_idx];
      cnt_new    = cnt_cur;

      if (upd_taken) begin
         if (cnt_cur != 2'b11) cnt_new = cnt_cur + 2'd1;
      end else begin
         if (cnt_cur != 2'b00) cnt_new = cnt_cur - 2'd1;
      end

      case (state_q)
         S_CLEAR: begin
            if (clr_req) sweep_d = '0;
            else if (sweep_q == LAST_IDX) state_d = S_IDLE;
            else sweep_d = sweep_q + IDX_W'(1);
         end
         S_IDLE: begin
            // An update in the same cycle is applied first; the sweep starts next edge.
            if (clr_req) begin
               state_d = S_CLEAR;
               sweep_d = '0;
            end
         end
      endcase

      if (upd_acc && br_cnt_q != 32'hFFFF_FFFF) br_cnt_d = br_cnt_q + 32'd1;
      if (mispredict) begin
         flush_d    = 1'b1;
         redirect_d = upd_taken ? upd_target : upd_pc + XLEN'(4);
         if (mis_cnt_q != 32'hFFFF_FFFF) mis_cnt_d = mis_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_CLEAR;
         sweep_q    <= '0;
         flush_q    <= 1'b0;
         redirect_q <= '0;
         br_cnt_q   <= '0;
         mis_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         sweep_q    <= sweep_d;
         flush_q    <= flush_d;
         redirect_q <= redirect_d;
         br_cnt_q   <= br_cnt_d;
         mis_cnt_q  <= mis_cnt_d;
      end
   end

   // Single write port: the sweep owns it in CLEAR, resolved branches in IDLE.
   always_ff @(posedge clk) begin
      if (state_q == S_CLEAR) table_q[sweep_q] <= 2'b00;
      else if (upd_acc) table_q[upd_idx] <= cnt_new;
   end

endmodule

// File: tb/tb_br_pred_ctrl.sv
// Bench for br_pred_ctrl: directed vector table, clear/saturation/reset sequences,
// and random traffic against an array-based predictor model.
module tb_br_pred_ctrl;
   localparam int ENTRIES = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clr_req = 1'b0;
   logic        busy;
   logic [31:0] lk_pc = '0;
   logic        lk_pred;
   logic        upd_valid = 1'b0;
   logic        upd_ready;
   logic [31:0] upd_pc = '0;
   logic        upd_taken = 1'b0;
   logic        upd_pred = 1'b0;
   logic [31:0] upd_target = '0;
   logic        flush;
   logic [31:0] redirect_pc;
   logic [31:0] br_cnt;
   logic [31:0] mis_cnt;

   br_pred_ctrl #(.ENTRIES(ENTRIES), .XLEN(32)) dut (
      .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy),
      .lk_pc(lk_pc), .lk_pred(lk_pred),
      .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
      .upd_taken(upd_taken), .upd_pred(upd_pred), .upd_target(upd_target),
      .flush(flush), .redirect_pc(redirect_pc), .br_cnt(br_cnt), .mis_cnt(mis_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: counter values 0..3 per entry, cycles of clearing left, stats.
   int          m_tab [ENTRIES];
   int          m_busy_left;
   logic [31:0] m_br, m_mis, m_redir;
   logic        m_flush;

   logic        obs_busy, obs_lk, obs_flush;
   logic [31:0] obs_br, obs_mis;

   typedef struct {
      logic        clr;
      logic        v;
      logic [31:0] pc;
      logic        taken;
      logic        pred;
      logic [31:0] tgt;
      logic [31:0] lk;
      logic        exp_lk;
      logic        exp_flush;
      logic [31:0] exp_redir;
   } vec_t;
   vec_t vecs [10];

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic int idx_of(logic [31:0] pc);
      return int'((pc / 4) % ENTRIES);
   endfunction

   task automatic model_reset();
      m_busy_left = ENTRIES;
      m_br = '0;
      m_mis = '0;
      m_flush = 1'b0;
      m_redir = '0;
      foreach (m_tab[k]) m_tab[k] = 0;
   endtask

   // Inputs are already driven (at a negedge); check, advance model, move to next negedge.
   task automatic cycle();
      logic exp_lk;
      int   i;
      #1;
      obs_busy  = busy;
      obs_lk    = lk_pred;
      obs_flush = flush;
      obs_br    = br_cnt;
      obs_mis   = mis_cnt;
      exp_lk = (m_busy_left == 0) && (m_tab[idx_of(lk_pc)] >= 2);
      chk("busy", 32'(busy), 32'(m_busy_left > 0));
      chk("upd_ready", 32'(upd_ready), 32'(m_busy_left == 0));
      chk("lk_pred", 32'(lk_pred), 32'(exp_lk));
      chk("flush", 32'(flush), 32'(m_flush));
      chk("redirect_pc", redirect_pc, m_redir);
      chk("br_cnt", br_cnt, m_br);
      chk("mis_cnt", mis_cnt, m_mis);

      m_flush = 1'b0;
      if (m_busy_left == 0 && upd_valid) begin
         i = idx_of(upd_pc);
         if (upd_taken) m_tab[i] = (m_tab[i] == 3) ? 3 : m_tab[i] + 1;
         else           m_tab[i] = (m_tab[i] == 0) ? 0 : m_tab[i] - 1;
         if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
         if (upd_pred != upd_taken) begin
            if (m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
            m_flush = 1'b1;
            m_redir = upd_taken ? upd_target : upd_pc + 32'd4;
         end
      end
      if (m_busy_left > 0) m_busy_left = clr_req ? ENTRIES : m_busy_left - 1;
      else if (clr_req) begin
         m_busy_left = ENTRIES;
         foreach (m_tab[k]) m_tab[k] = 0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_until_idle(output int n);
      n = 0;
      for (int k = 0; k < 40; k++) begin
         cycle();
         if (!obs_busy) break;
         n++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      chk("rst_flush", 32'(flush), 32'h0);
      chk("rst_redirect", redirect_pc, 32'h0);
      chk("rst_br_cnt", br_cnt, 32'h0);
      chk("rst_mis_cnt", mis_cnt, 32'h0);
      chk("rst_busy", 32'(busy), 32'h1);
      chk("rst_upd_ready", 32'(upd_ready), 32'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int n;
      vecs[0] = '{1'b0, 1'b1, 32'h40,  1'b1, 1'b0, 32'h1000, 32'h40,  1'b0, 1'b1, 32'h1000};
      vecs[1] = '{1'b0, 1'b1, 32'h40,  1'b1, 1'b0, 32'h1000, 32'h40,  1'b0, 1'b1, 32'h1000};
      vecs[2] = '{1'b0, 1'b1, 32'h40,  1'b1, 1'b1, 32'h1000, 32'h40,  1'b1, 1'b0, 32'h1000};
      vecs[3] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    32'h40,  1'b1, 1'b0, 32'h1000};
      vecs[4] = '{1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 32'h999,  32'h100, 1'b1, 1'b1, 32'h104};
      vecs[5] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    32'h40,  1'b1, 1'b0, 32'h104};
      vecs[6] = '{1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 32'h80,   32'h200, 1'b1, 1'b1, 32'h80};
      vecs[7] = '{1'b0, 1'b1, 32'h80,  1'b0, 1'b1, 32'h0,    32'h80,  1'b1, 1'b1, 32'h84};
      vecs[8] = '{1'b0, 1'b1, 32'h40,  1'b0, 1'b1, 32'h0,    32'h80,  1'b1, 1'b1, 32'h44};
      vecs[9] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    32'h40,  1'b0, 1'b0, 32'h44};

      @(negedge clk);
      do_reset();
      n = 0;
      for (int k = 0; k < 40; k++) begin
         lk_pc = 32'((k % ENTRIES) * 4);
         cycle();
         if (!obs_busy) break;
         n++;
      end
      chk("reset_busy_cycles", 32'(n), 32'd16);
      for (int k = 0; k < ENTRIES; k++) begin
         lk_pc = 32'(k * 4);
         cycle();
         chk("lk_after_clear", 32'(obs_lk), 32'h0);
      end

      // Training, redirects, same-cycle hazard and aliasing.
      for (int k = 0; k < 10; k++) begin
         clr_req = vecs[k].clr;   upd_valid = vecs[k].v;     upd_pc = vecs[k].pc;
         upd_taken = vecs[k].taken; upd_pred = vecs[k].pred; upd_target = vecs[k].tgt;
         lk_pc = vecs[k].lk;
         cycle();
         chk($sformatf("vec%0d_lk_pred", k), 32'(obs_lk), 32'(vecs[k].exp_lk));
         chk($sformatf("vec%0d_flush", k), 32'(flush), 32'(vecs[k].exp_flush));
         chk($sformatf("vec%0d_redirect", k), redirect_pc, vecs[k].exp_redir);
      end
      upd_valid = 1'b0;
      chk("vec_br_cnt", br_cnt, 32'd7);
      chk("vec_mis_cnt", mis_cnt, 32'd6);

      // Update together with clear in IDLE, then updates offered during the sweep.
      clr_req = 1'b1; upd_valid = 1'b1; upd_pc = 32'h44; upd_taken = 1'b1; upd_pred = 1'b0;
      upd_target = 32'h300;
      cycle();
      clr_req = 1'b0;
      cycle();
      chk("clr_upd_busy", 32'(obs_busy), 32'h1);
      chk("clr_upd_flush", 32'(obs_flush), 32'h1);
      chk("clr_upd_br", obs_br, 32'd8);
      run_until_idle(n);
      chk("clr_upd_busy_cycles", 32'(n + 1), 32'd16);
      chk("sweep_br_frozen", obs_br, 32'd8);
      chk("sweep_mis_frozen", obs_mis, 32'd7);
      upd_valid = 1'b0;

      // Clear request at sweep cycle 10 restarts the sweep.
      clr_req = 1'b1;
      cycle();
      clr_req = 1'b0;
      for (int k = 0; k < 10; k++) cycle();
      clr_req = 1'b1;
      cycle();
      clr_req = 1'b0;
      run_until_idle(n);
      chk("restart_busy_cycles", 32'(n), 32'd16);

      // Saturation of both statistics counters.
      force dut.br_cnt_q = 32'hFFFF_FFFF;
      force dut.mis_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.br_cnt_q;
      release dut.mis_cnt_q;
      m_br = 32'hFFFF_FFFF;
      m_mis = 32'hFFFF_FFFF;
      upd_valid = 1'b1; upd_pc = 32'h8; upd_taken = 1'b1; upd_pred = 1'b0; upd_target = 32'h20;
      cycle();
      upd_valid = 1'b0;
      chk("sat_br_cnt", br_cnt, 32'hFFFF_FFFF);
      chk("sat_mis_cnt", mis_cnt, 32'hFFFF_FFFF);
      chk("sat_flush", 32'(flush), 32'h1);
      cycle();

      // Reset while a flush is pending.
      upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b1; upd_pred = 1'b0; upd_target = 32'h500;
      cycle();
      upd_valid = 1'b0;
      chk("pending_flush", 32'(flush), 32'h1);
      do_reset();
      run_until_idle(n);
      chk("rst2_busy_cycles", 32'(n), 32'd16);

      // Random traffic against the model.
      for (int k = 0; k < 600; k++) begin
         clr_req    = ($urandom_range(0, 39) == 0);
         upd_valid  = $urandom_range(0, 1) == 1;
         upd_pc     = $urandom;
         upd_taken  = $urandom_range(0, 1) == 1;
         upd_pred   = $urandom_range(0, 1) == 1;
         upd_target = $urandom;
         lk_pc      = ($urandom_range(0, 3) == 0) ? upd_pc : $urandom;
         cycle();
      end
      clr_req = 1'b0;
      upd_valid = 1'b0;
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end
endmodule
